registro_solicitudes: RTL and testbench

//  Consumer of the 4-bit button code (0=none, 1-4 cabin floor 1-4, 5=S1, 6=B2,
//  7=S2, 8=B3, 9=S3, 10=B4). Filters each code for stability and accepts each

---
 rtl/registro_solicitudes_if.sv | 26 ++
 rtl/registro_solicitudes.sv | 147 ++++++++++++++
 tb/tb_registro_solicitudes.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/registro_solicitudes_if.sv
// Bus between the button encoder / elevator controller and the request register.
// The master drives button codes and floor service; the slave reports pending calls.
interface registro_solicitudes_if;
   logic [3:0] boton_pres;
   logic [1:0] piso_actual;
   logic       atendido;
   logic [3:0] pend_cabina;
   logic [2:0] pend_sube;
   logic [2:0] pend_baja;
   logic [3:0] pend_piso;
   logic       hay_solicitud;
   logic       codigo_nuevo;
   logic       codigo_invalido;

   modport master (
      output boton_pres, piso_actual, atendido,
      input  pend_cabina, pend_sube, pend_baja, pend_piso,
      input  hay_solicitud, codigo_nuevo, codigo_invalido
   );

   modport slave (
      input  boton_pres, piso_actual, atendido,
      output pend_cabina, pend_sube, pend_baja, pend_piso,
      output hay_solicitud, codigo_nuevo, codigo_invalido
   );
endinterface

// File: rtl/registro_solicitudes.sv
// Debounces the 4-bit button code, accepts each press once and keeps per-floor
// pending cabin/up/down requests until the car serves that floor.
module registro_solicitudes #(
   parameter int unsigned ESTABLE = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   registro_solicitudes_if.slave bus
);

   localparam int unsigned CW       = 4;
   localparam logic [CW-1:0] ESTABLE_C = CW'(ESTABLE);

   typedef enum logic [1:0] {
      ESPERA    = 2'd0,
      FILTRANDO = 2'd1,
      ACEPTADO  = 2'd2
   } estado_t;

   estado_t       r_estado, w_estado_sig;
   logic [CW-1:0] r_cod_ult, w_cod_sig;
   logic [CW-1:0] r_cnt, w_cnt_sig, w_cnt_inc;
   logic          w_acepta;

   logic [3:0] r_pend_cabina, w_set_cab, w_clr_cab;
   logic [2:0] r_pend_sube, w_set_sube, w_clr_sube;
   logic [2:0] r_pend_baja, w_set_baja, w_clr_baja;
   logic       r_codigo_nuevo, r_codigo_invalido;
   logic       w_valido, w_invalido;

   assign w_cnt_inc = r_cnt + 4'd1;

   // Stability filter: a code must be seen ESTABLE consecutive edges, held codes accepted once
   always_comb begin
      w_estado_sig = r_estado;
      w_cod_sig    = r_cod_ult;
      w_cnt_sig    = r_cnt;
      w_acepta     = 1'b0;
      case (r_estado)
         ESPERA, ACEPTADO: begin
            if (bus.boton_pres == 4'd0) begin
               w_estado_sig = ESPERA;
               w_cnt_sig    = 4'd0;
            end else if (!(r_estado == ACEPTADO && bus.boton_pres == r_cod_ult)) begin
               w_cod_sig = bus.boton_pres;
               w_cnt_sig = 4'd1;
               if (ESTABLE_C == 4'd1) begin
                  w_acepta     = 1'b1;
                  w_estado_sig = ACEPTADO;
               end else begin
                  w_estado_sig = FILTRANDO;
               end
            end
         end
         FILTRANDO: begin
            if (bus.boton_pres == 4'd0) begin
               w_estado_sig = ESPERA;
               w_cnt_sig    = 4'd0;
            end else if (bus.boton_pres != r_cod_ult) begin
               w_cod_sig = bus.boton_pres;
               w_cnt_sig = 4'd1;
            end else begin
               w_cnt_sig = w_cnt_inc;
               if (w_cnt_inc == ESTABLE_C) begin
                  w_acepta     = 1'b1;
                  w_estado_sig = ACEPTADO;
               end
            end
         end
         default: begin
            w_estado_sig = ESPERA;
            w_cnt_sig    = 4'd0;
         end
      endcase
   end

   // Accepted code -> request bit to set
   always_comb begin
      w_set_cab  = 4'b0000;
      w_set_sube = 3'b000;
      w_set_baja = 3'b000;
      if (w_acepta) begin
         case (w_cod_sig)
            4'd1:    w_set_cab[0]  = 1'b1;
            4'd2:    w_set_cab[1]  = 1'b1;
            4'd3:    w_set_cab[2]  = 1'b1;
            4'd4:    w_set_cab[3]  = 1'b1;
            4'd5:    w_set_sube[0] = 1'b1;
            4'd6:    w_set_baja[0] = 1'b1;
            4'd7:    w_set_sube[1] = 1'b1;
            4'd8:    w_set_baja[1] = 1'b1;
            4'd9:    w_set_sube[2] = 1'b1;
            4'd10:   w_set_baja[2] = 1'b1;
            default: ;
         endcase
      end
   end

   assign w_valido   = w_acepta && (w_cod_sig <= 4'd10);
   assign w_invalido = w_acepta && (w_cod_sig >  4'd10);

   // Served floor -> request bits to clear (no up call at the top, no down call at the bottom)
   always_comb begin
      w_clr_cab  = 4'b0000;
      w_clr_sube = 3'b000;
      w_clr_baja = 3'b000;
      if (bus.atendido) begin
         case (bus.piso_actual)
            2'd0: begin w_clr_cab = 4'b0001; w_clr_sube = 3'b001; end
            2'd1: begin w_clr_cab = 4'b0010; w_clr_sube = 3'b010; w_clr_baja = 3'b001; end
            2'd2: begin w_clr_cab = 4'b0100; w_clr_sube = 3'b100; w_clr_baja = 3'b010; end
            default: begin w_clr_cab = 4'b1000; w_clr_baja = 3'b100; end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_estado          <= ESPERA;
         r_cod_ult         <= 4'd0;
         r_cnt             <= 4'd0;
         r_pend_cabina     <= 4'b0000;
         r_pend_sube       <= 3'b000;
         r_pend_baja       <= 3'b000;
         r_codigo_nuevo    <= 1'b0;
         r_codigo_invalido <= 1'b0;
      end else begin
         r_estado          <= w_estado_sig;
         r_cod_ult         <= w_cod_sig;
         r_cnt             <= w_cnt_sig;
         r_pend_cabina     <= (r_pend_cabina | w_set_cab)  & ~w_clr_cab;
         r_pend_sube       <= (r_pend_sube   | w_set_sube) & ~w_clr_sube;
         r_pend_baja       <= (r_pend_baja   | w_set_baja) & ~w_clr_baja;
         r_codigo_nuevo    <= w_valido;
         r_codigo_invalido <= w_invalido;
      end
   end

   assign bus.pend_cabina     = r_pend_cabina;
   assign bus.pend_sube       = r_pend_sube;
   assign bus.pend_baja       = r_pend_baja;
   assign bus.pend_piso       = r_pend_cabina | {1'b0, r_pend_sube} | {r_pend_baja, 1'b0};
   assign bus.hay_solicitud   = |bus.pend_piso;
   assign bus.codigo_nuevo    = r_codigo_nuevo;
   assign bus.codigo_invalido = r_codigo_invalido;

endmodule

// File: tb/tb_registro_solicitudes.sv
// Directed bench for registro_solicitudes (ESTABLE=2) with hand-computed expectations.
module tb_registro_solicitudes;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   registro_solicitudes_if bus ();

   registro_solicitudes #(.ESTABLE(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge; inputs change and outputs are sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] cab, input logic [2:0] sube,
                            input logic [2:0] baja, input logic nuevo, input logic inval);
      logic [3:0] piso;
      piso = cab | {1'b0, sube} | {baja, 1'b0};
      check_eq({tag, ".cab"},   32'(bus.pend_cabina),     32'(cab));
      check_eq({tag, ".sube"},  32'(bus.pend_sube),       32'(sube));
      check_eq({tag, ".baja"},  32'(bus.pend_baja),       32'(baja));
      check_eq({tag, ".piso"},  32'(bus.pend_piso),       32'(piso));
      check_eq({tag, ".hay"},   32'(bus.hay_solicitud),   32'(|piso));
      check_eq({tag, ".nuevo"}, 32'(bus.codigo_nuevo),    32'(nuevo));
      check_eq({tag, ".inval"}, 32'(bus.codigo_invalido), 32'(inval));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Clean two-edge press followed by release
   task automatic press(input logic [3:0] code);
      bus.boton_pres = code;
      tick();
      tick();
      bus.boton_pres = 4'd0;
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.boton_pres  = 4'd0;
      bus.piso_actual = 2'd0;
      bus.atendido    = 1'b0;
      reset           = 1'b0;
      #1;
      do_reset();
      check_all("rst", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0);

      // 1: code 3 held five cycles
      bus.boton_pres = 4'd3;
      tick();
      check_all("t1.e1", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0);
      tick();
      check_all("t1.e2", 4'b0100, 3'b000, 3'b000, 1'b1, 1'b0);
      tick();
      check_all("t1.e3", 4'b0100, 3'b000, 3'b000, 1'b0, 1'b0);
      tick();
      tick();
      check_all("t1.e5", 4'b0100, 3'b000, 3'b000, 1'b0, 1'b0);
      bus.boton_pres = 4'd0;
      tick();

      // 2: one-cycle glitch of code 7 is ignored, then a real press
      do_reset();
      bus.boton_pres = 4'd7;
      tick();
      bus.boton_pres = 4'd0;
      tick();
      check_all("t2.glitch", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0);
      bus.boton_pres = 4'd7;
      tick();
      check_all("t2.e1", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0);
      tick();
      check_all("t2.e2", 4'b0000, 3'b010, 3'b000, 1'b1, 1'b0);
      check_eq("t2.piso_lit", 32'(bus.pend_piso), 32'(4'b0010));
      bus.boton_pres = 4'd0;
      tick();

      // 3: code 2 held, then directly code 10
      bus.boton_pres = 4'd2;
      tick();
      tick();
      check_all("t3.c2", 4'b0010, 3'b010, 3'b000, 1'b1, 1'b0);
      tick();
      check_all("t3.hold", 4'b0010, 3'b010, 3'b000, 1'b0, 1'b0);
      bus.boton_pres = 4'd10;
      tick();
      check_all("t3.c10e1", 4'b0010, 3'b010, 3'b000, 1'b0, 1'b0);
      tick();
      check_all("t3.c10e2", 4'b0010, 3'b010, 3'b100, 1'b1, 1'b0);
      bus.boton_pres = 4'd0;
      tick();

      // 4: service floor 3 (piso_actual=2), then accept/clear collisions
      do_reset();
      press(4'd3);
      press(4'd9);
      press(4'd8);
      press(4'd1);
      press(4'd5);
      check_all("t4.set", 4'b0101, 3'b101, 3'b010, 1'b0, 1'b0);
      bus.piso_actual = 2'd2;
      bus.atendido    = 1'b1;
      tick();
      bus.atendido    = 1'b0;
      check_all("t4.clr", 4'b0001, 3'b001, 3'b000, 1'b0, 1'b0);
      bus.boton_pres = 4'd3;
      tick();
      bus.atendido = 1'b1;
      tick();
      bus.atendido   = 1'b0;
      bus.boton_pres = 4'd0;
      check_all("t4.same", 4'b0001, 3'b001, 3'b000, 1'b1, 1'b0);
      tick();
      bus.boton_pres = 4'd4;
      tick();
      bus.piso_actual = 2'd0;
      bus.atendido    = 1'b1;
      tick();
      bus.atendido   = 1'b0;
      bus.boton_pres = 4'd0;
      check_all("t4.diff", 4'b1000, 3'b000, 3'b000, 1'b1, 1'b0);
      tick();

      // 5: invalid code 13 held three cycles
      bus.boton_pres = 4'd13;
      tick();
      tick();
      check_all("t5.e2", 4'b1000, 3'b000, 3'b000, 1'b0, 1'b1);
      tick();
      check_all("t5.e3", 4'b1000, 3'b000, 3'b000, 1'b0, 1'b0);
      bus.boton_pres = 4'd0;
      tick();

      // 6: asynchronous reset in the middle of filtering, button kept held
      press(4'd5);
      bus.boton_pres = 4'd2;
      tick();
      reset = 1'b1;
      #1;
      check_all("t6.async", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      check_all("t6.e1", 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0);
      tick();
      check_all("t6.e2", 4'b0010, 3'b000, 3'b000, 1'b1, 1'b0);
      bus.boton_pres = 4'd0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
